// File: rtl/pyjamask_core_param.sv
`default_nettype none
// ============================================================================
// Module  : pyjamask_core_param
// Brief   : Iterative Pyjamask-96/128 encryption core, one round per clock,
//           on-the-fly key schedule, BUS_W-bit valid/ready streams.
// Rev     : 1.0
// ============================================================================
module pyjamask_core_param #(
    parameter int ROWS    = 3,
    parameter int BUS_W   = 8,
    parameter int NROUNDS = 14
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] in_data,
    input  logic             reuse_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BUS_W-1:0] out_data,
    output logic             out_last,
    output logic             busy
);
    localparam int SW   = ROWS * 32;
    localparam int KW   = 128 / BUS_W;
    localparam int BW   = SW / BUS_W;
    localparam int MAXW = (KW > BW) ? KW : BW;
    localparam int CW   = $clog2(MAXW);
    localparam int RW   = $clog2(NROUNDS + 1);

    localparam logic [31:0] MK = 32'hb881b9ca;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_KEY = 3'd1;
    localparam logic [2:0] S_LOAD_BLK = 3'd2;
    localparam logic [2:0] S_ROUND    = 3'd3;
    localparam logic [2:0] S_FINAL    = 3'd4;
    localparam logic [2:0] S_OUT      = 3'd5;

    logic [2:0]    r_fsm;
    logic [SW-1:0] r_state;
    logic [127:0]  r_key;
    logic [127:0]  r_rk;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_round;
    logic          r_key_ok;

    logic [SW-1:0] w_ark;
    logic [SW-1:0] w_sb;
    logic [SW-1:0] w_mr;
    logic [127:0]  w_ks;
    logic          w_in_beat;

    // y = XOR_j x[31-j] ? rotr(m, j); rotr(m, j) is a 32-bit window of {m, m}
    function automatic logic [31:0] circ_mul(input logic [31:0] m, input logic [31:0] x);
        logic [31:0] acc;
        logic [63:0] mm;
        acc = '0;
        mm  = {m, m};
        for (int j = 0; j < 32; j++) begin
            if (x[31-j]) acc ^= mm[j +: 32];
        end
        return acc;
    endfunction

    function automatic logic [3:0] sbox(input logic [3:0] v);
        logic [3:0] o;
        o = '0;
        if (ROWS == 3) begin
            case (v[2:0])
                3'd0: o = 4'h1;  3'd1: o = 4'h3;  3'd2: o = 4'h6;  3'd3: o = 4'h5;
                3'd4: o = 4'h2;  3'd5: o = 4'h4;  3'd6: o = 4'h7;  default: o = 4'h0;
            endcase
        end else begin
            case (v)
                4'h0: o = 4'h2;  4'h1: o = 4'hd;  4'h2: o = 4'h3;  4'h3: o = 4'h9;
                4'h4: o = 4'h7;  4'h5: o = 4'hb;  4'h6: o = 4'ha;  4'h7: o = 4'h6;
                4'h8: o = 4'he;  4'h9: o = 4'h0;  4'ha: o = 4'hf;  4'hb: o = 4'h4;
                4'hc: o = 4'h8;  4'hd: o = 4'h5;  4'he: o = 4'h1;  default: o = 4'hc;
            endcase
        end
        return o;
    endfunction

    function automatic logic [31:0] mrow(input int i);
        logic [31:0] m;
        case (i)
            0:       m = 32'ha3861085;
            1:       m = 32'h63417021;
            2:       m = 32'h692cf280;
            default: m = 32'h48a54813;
        endcase
        return m;
    endfunction

    // Row i occupies bits [SW-32*i-1 : SW-32*(i+1)], so row 0 is the MSB word.
    always_comb begin : p_round
        logic [3:0] col;
        logic [3:0] sub;
        col   = '0;
        sub   = '0;
        w_ark = r_state ^ r_rk[127 -: SW];
        w_sb  = '0;
        w_mr  = '0;
        for (int c = 0; c < 32; c++) begin
            col = '0;
            for (int i = 0; i < ROWS; i++) col[ROWS-1-i] = w_ark[SW-32*(i+1)+c];
            sub = sbox(col);
            for (int i = 0; i < ROWS; i++) w_sb[SW-32*(i+1)+c] = sub[ROWS-1-i];
        end
        for (int i = 0; i < ROWS; i++) begin
            w_mr[SW-32*(i+1) +: 32] = circ_mul(mrow(i), w_sb[SW-32*(i+1) +: 32]);
        end
    end

    always_comb begin : p_keysched
        logic [31:0] k0, k1, k2, k3, t;
        k0 = r_rk[127:96];
        k1 = r_rk[95:64];
        k2 = r_rk[63:32];
        k3 = r_rk[31:0];
        t  = k0 ^ k1 ^ k2 ^ k3;
        k0 = k0 ^ t;
        k1 = k1 ^ t;
        k2 = k2 ^ t;
        k3 = k3 ^ t;
        k0 = circ_mul(MK, k0);
        k1 = {k1[23:0], k1[31:24]};
        k2 = {k2[16:0], k2[31:17]};
        k3 = {k3[13:0], k3[31:14]};
        k0 = k0 ^ 32'h00000080 ^ 32'(r_round);
        k1 = k1 ^ 32'h00006a00;
        k2 = k2 ^ 32'h003f0000;
        k3 = k3 ^ 32'h24000000;
        w_ks = {k0, k1, k2, k3};
    end

    assign w_in_beat = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_fsm    <= S_IDLE;
            r_state  <= '0;
            r_key    <= '0;
            r_rk     <= '0;
            r_cnt    <= '0;
            r_round  <= '0;
            r_key_ok <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (w_in_beat) begin
                        r_cnt <= CW'(1);
                        if (reuse_key && r_key_ok) begin
                            r_state <= {r_state[SW-BUS_W-1:0], in_data};
                            r_fsm   <= S_LOAD_BLK;
                        end else begin
                            r_key    <= {r_key[127-BUS_W:0], in_data};
                            r_key_ok <= 1'b0;
                            r_fsm    <= S_LOAD_KEY;
                        end
                    end
                end
                S_LOAD_KEY: begin
                    if (w_in_beat) begin
                        r_key <= {r_key[127-BUS_W:0], in_data};
                        if (r_cnt == CW'(KW - 1)) begin
                            r_cnt    <= '0;
                            r_key_ok <= 1'b1;
                            r_fsm    <= S_LOAD_BLK;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_LOAD_BLK: begin
                    if (w_in_beat) begin
                        r_state <= {r_state[SW-BUS_W-1:0], in_data};
                        if (r_cnt == CW'(BW - 1)) begin
                            r_cnt   <= '0;
                            r_rk    <= r_key;
                            r_round <= '0;
                            r_fsm   <= S_ROUND;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_ROUND: begin
                    r_state <= w_mr;
                    r_rk    <= w_ks;
                    r_round <= r_round + RW'(1);
                    if (r_round == RW'(NROUNDS - 1)) r_fsm <= S_FINAL;
                end
                S_FINAL: begin
                    r_state <= r_state ^ r_rk[127 -: SW];
                    r_cnt   <= '0;
                    r_fsm   <= S_OUT;
                end
                S_OUT: begin
                    // The output word is the top slice of r_state, so stalls hold it naturally.
                    if (out_ready) begin
                        r_state <= {r_state[SW-BUS_W-1:0], {BUS_W{1'b0}}};
                        if (r_cnt == CW'(BW - 1)) begin
                            r_cnt <= '0;
                            r_fsm <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = !reset_n && ((r_fsm == S_IDLE) || (r_fsm == S_LOAD_KEY) || (r_fsm == S_LOAD_BLK));
    assign out_valid = (r_fsm == S_OUT);
    assign out_data  = out_valid ? r_state[SW-1 -: BUS_W] : '0;
    assign out_last  = out_valid && (r_cnt == CW'(BW - 1));
    assign busy      = (r_fsm != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pyjamask_core_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_pyjamask_core_param
// Brief   : Directed self-checking bench for Pyjamask-96 (8-bit bus) and
//           Pyjamask-128 (32-bit bus) core instances.
// Rev     : 1.0
// ============================================================================
module tb_pyjamask_core_param;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;

    logic        a_in_valid = 1'b0, a_in_ready, a_reuse = 1'b0;
    logic [7:0]  a_in_data = '0;
    logic        a_out_valid, a_out_ready = 1'b1, a_out_last, a_busy;
    logic [7:0]  a_out_data;

    logic        b_in_valid = 1'b0, b_in_ready, b_reuse = 1'b0;
    logic [31:0] b_in_data = '0;
    logic        b_out_valid, b_out_ready = 1'b1, b_out_last, b_busy;
    logic [31:0] b_out_data;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] P1 = 128'h0000000050796a616d61736b2d39363a;
    localparam logic [127:0] P2 = 128'h0000000000112233445566778899aabb;
    localparam logic [127:0] PB = 128'h50796a616d61736b2d3132383a292900;

    localparam logic [23:0]  SB3 = 24'b001_011_110_101_010_100_111_000;
    localparam logic [63:0]  SB4 = 64'h2d397ba6e0f4851c;
    localparam logic [127:0] MR  = 128'ha3861085_63417021_692cf280_48a54813;

    pyjamask_core_param dut96 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .reuse_key(a_reuse), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy)
    );

    pyjamask_core_param #(.ROWS(4), .BUS_W(32), .NROUNDS(14)) dut128 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .reuse_key(b_reuse), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference-style matrix product: walk the input bits MSB first, rotating the column.
    function automatic logic [31:0] mm(input logic [31:0] mcol, input logic [31:0] v);
        logic [31:0] res;
        res = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) res ^= mcol;
            mcol = {mcol[0], mcol[31:1]};
        end
        return mm_ret(res);
    endfunction

    function automatic logic [31:0] mm_ret(input logic [31:0] x);
        return x;
    endfunction

    // Returns ciphertext right-aligned (rows*32 bits); pt is right-aligned as well.
    function automatic logic [127:0] model(input int rows, input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  s [4];
        logic [31:0]  k [4];
        logic [31:0]  t;
        logic [3:0]   v, o;
        logic [127:0] ct;
        for (int i = 0; i < 4; i++) begin
            k[i] = key[127-32*i -: 32];
            s[i] = '0;
            if (i < rows) s[i] = pt[32*(rows-1-i) +: 32];
        end
        for (int r = 0; r < 14; r++) begin
            for (int i = 0; i < rows; i++) s[i] ^= k[i];
            for (int c = 0; c < 32; c++) begin
                v = '0;
                for (int i = 0; i < rows; i++) v = {v[2:0], s[i][c]};
                if (rows == 3) o = {1'b0, SB3[23-3*int'(v) -: 3]};
                else           o = SB4[63-4*int'(v) -: 4];
                for (int i = 0; i < rows; i++) s[i][c] = o[rows-1-i];
            end
            for (int i = 0; i < rows; i++) s[i] = mm(MR[127-32*i -: 32], s[i]);
            t = k[0] ^ k[1] ^ k[2] ^ k[3];
            for (int i = 0; i < 4; i++) k[i] ^= t;
            k[0] = mm(32'hb881b9ca, k[0]);
            k[1] = {k[1][23:0], k[1][31:24]};
            k[2] = {k[2][16:0], k[2][31:17]};
            k[3] = {k[3][13:0], k[3][31:14]};
            k[0] ^= 32'h00000080 ^ 32'(r);
            k[1] ^= 32'h00006a00;
            k[2] ^= 32'h003f0000;
            k[3] ^= 32'h24000000;
        end
        ct = '0;
        for (int i = 0; i < rows; i++) ct[32*(rows-1-i) +: 32] = s[i] ^ k[i];
        return ct;
    endfunction

    task automatic sample(input bit b, output logic ov, output logic ol, output logic ir,
                          output logic bz, output logic [31:0] od);
        ov = b ? b_out_valid : a_out_valid;
        ol = b ? b_out_last  : a_out_last;
        ir = b ? b_in_ready  : a_in_ready;
        bz = b ? b_busy      : a_busy;
        od = b ? b_out_data  : {24'b0, a_out_data};
    endtask

    task automatic send(input bit b, input logic [31:0] d, input logic rk, input bit gaps, input string tag);
        int n;
        logic ir;
        if (gaps) repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            a_in_data = 8'($urandom);
            b_in_data = $urandom;
        end
        @(negedge clk);
        if (b) begin b_in_valid = 1'b1; b_in_data = d;      b_reuse = rk; end
        else   begin a_in_valid = 1'b1; a_in_data = d[7:0]; a_reuse = rk; end
        n  = 0;
        ir = b ? b_in_ready : a_in_ready;
        while (ir !== 1'b1 && n < 20) begin
            @(negedge clk);
            ir = b ? b_in_ready : a_in_ready;
            n++;
        end
        if (n >= 20) chk({tag, "_in_ready_timeout"}, 128'(ir), 128'(1));
        @(posedge clk);
        #1;
        a_in_valid = 1'b0; a_reuse = 1'b0;
        b_in_valid = 1'b0; b_reuse = 1'b0;
    endtask

    task automatic run(input bit b, input logic [127:0] key, input logic [127:0] pt,
                       input bit send_key, input bit reuse_flag, input bit gaps,
                       input bit rnd, input string tag);
        int nk, nb, w, m, nw, guard, bad_rdy, bad_last, bad_stab;
        logic ov, ol, ir, bz, held_last, rdy, stalled;
        logic [31:0]  od, held;
        logic [127:0] exp_ct, got;
        nk = b ? 4 : 16;
        nb = b ? 4 : 12;
        w  = b ? 32 : 8;
        exp_ct = model(b ? 4 : 3, key, pt);
        if (send_key)
            for (int i = 0; i < nk; i++)
                send(b, 32'(key >> (128 - w*(i+1))), (i == 0) ? reuse_flag : 1'b0, gaps, tag);
        for (int i = 0; i < nb; i++)
            send(b, 32'(pt >> (w*(nb-1-i))), (!send_key && i == 0) ? reuse_flag : 1'b0, gaps, tag);

        bad_rdy = 0;
        m = 0;
        forever begin
            @(negedge clk);
            sample(b, ov, ol, ir, bz, od);
            if (ov === 1'b1 || m >= 40) break;
            if (ir !== 1'b0 || bz !== 1'b1) bad_rdy++;
            m++;
        end
        chk({tag, "_latency"}, 128'(m + 1), 128'(16));

        got = '0; nw = 0; guard = 0; bad_last = 0; bad_stab = 0;
        stalled = 1'b0; held = '0; held_last = 1'b0;
        while (nw < nb && guard < 200) begin
            if (ov === 1'b1) begin
                if (stalled && (od !== held || ol !== held_last)) bad_stab++;
                rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (b) b_out_ready = rdy; else a_out_ready = rdy;
                if (rdy) begin
                    got = (got << w) | 128'(od);
                    if (ol !== (nw == nb - 1)) bad_last++;
                    nw++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held      = od;
                    held_last = ol;
                end
            end
            if (ir !== 1'b0) bad_rdy++;
            @(negedge clk);
            sample(b, ov, ol, ir, bz, od);
            guard++;
        end
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        chk({tag, "_ciphertext"}, got, exp_ct);
        chk({tag, "_beats"}, 128'(nw), 128'(nb));
        chk({tag, "_out_last"}, 128'(bad_last), 128'(0));
        chk({tag, "_stall_hold"}, 128'(bad_stab), 128'(0));
        chk({tag, "_in_ready_low"}, 128'(bad_rdy), 128'(0));
        chk({tag, "_idle_after"}, 128'({ov, bz, ir}), 128'(3'b001));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_outputs", 128'({a_in_ready, a_out_valid, a_out_last, a_out_data, a_busy}), 128'(0));
        chk("rst_b_outputs", 128'({b_in_ready, b_out_valid, b_out_last, b_out_data, b_busy}), 128'(0));
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("idle_a", 128'({a_in_ready, a_busy, a_out_valid}), 128'(3'b100));
        chk("idle_b", 128'({b_in_ready, b_busy, b_out_valid}), 128'(3'b100));

        run(1'b0, K1, P1, 1'b1, 1'b0, 1'b0, 1'b0, "p96_full");
        run(1'b0, K1, P1, 1'b0, 1'b1, 1'b0, 1'b0, "p96_reuse");
        run(1'b0, K1, P2, 1'b0, 1'b1, 1'b0, 1'b1, "p96_reuse_stall");
        run(1'b0, K2, P2, 1'b1, 1'b0, 1'b1, 1'b1, "p96_gaps_k2");
        run(1'b0, K1, P1, 1'b1, 1'b0, 1'b1, 1'b0, "p96_gaps_k1");

        // Abort a job mid-round, then a reuse request must fall back to a full key load.
        for (int i = 0; i < 16; i++) send(1'b0, 32'(K1 >> (120 - 8*i)), 1'b0, 1'b0, "abort");
        for (int i = 0; i < 12; i++) send(1'b0, 32'(P1 >> (88 - 8*i)), 1'b0, 1'b0, "abort");
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("abort_in_round", 128'({a_busy, a_in_ready, a_out_valid}), 128'(3'b100));
        reset_n = 1'b1;
        #1;
        chk("abort_async", 128'({a_in_ready, a_out_valid, a_out_last, a_out_data, a_busy}), 128'(0));
        @(posedge clk);
        #1;
        chk("abort_edge", 128'({a_in_ready, a_out_valid, a_out_last, a_out_data, a_busy}), 128'(0));
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_release", 128'({a_in_ready, a_busy}), 128'(2'b10));
        run(1'b0, K1, P1, 1'b1, 1'b1, 1'b0, 1'b0, "p96_after_reset");

        run(1'b1, K1, PB, 1'b1, 1'b0, 1'b0, 1'b0, "p128_full");
        run(1'b1, K1, PB, 1'b0, 1'b1, 1'b0, 1'b1, "p128_reuse_stall");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
